// File: rtl/chunked_adder_seq.sv
//------------------------------------------------------------------------------
// Module      : chunked_adder_seq (with shared W-bit adder)
// Description : Adds two N-bit operands by reusing one W-bit adder over
//               N/W cycles, LSB chunk first, with valid/ready handshakes on
//               the request and result sides.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_carry_in,
   output logic [N-1:0] o_s,
   output logic         o_carry_out
);

   // One extra bit on each operand captures the carry out of the top bit
   assign {o_carry_out, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_carry_in};

endmodule

module chunked_adder_seq #(
   parameter int N = 64,
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_carry_in,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_s,
   output logic         o_carry_out,
   output logic         o_busy
);

   localparam int c_k  = N / W;
   localparam int c_cw = (c_k > 1) ? $clog2(c_k) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(c_k - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   // Operand width must be a whole, non-zero number of chunks
   generate
      if ((N % W) != 0 || N < W) begin : g_param_check
         $error("chunked_adder_seq: N must be a non-zero multiple of W");
      end
   endgenerate

   logic [1:0]                r_state;
   logic [1:0]                w_state_nxt;
   logic [c_cw-1:0]           r_cnt;
   logic                      r_carry;
   logic [c_k-1:0][W-1:0]     r_a;
   logic [c_k-1:0][W-1:0]     r_b;
   logic [c_k-1:0][W-1:0]     r_s;
   logic                      r_cout;
   logic [W-1:0]              w_sum;
   logic                      w_cout;
   logic                      w_accept;

   assign w_accept = i_valid && (r_state == c_idle);

   // Single shared chunk adder, fed by the chunk selected by the counter
   adder #(
      .N(W)
   ) u_adder (
      .i_a         (r_a[r_cnt]),
      .i_b         (r_b[r_cnt]),
      .i_carry_in  (r_carry),
      .o_s         (w_sum),
      .o_carry_out (w_cout)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, step through chunks, wait for consumer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: if (i_valid)          w_state_nxt = c_run;
         c_run:  if (r_cnt == c_last)  w_state_nxt = c_done;
         c_done: if (i_ready)          w_state_nxt = c_idle;
         default:                      w_state_nxt = c_idle;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_busy  = 1'b0;
      case (r_state)
         c_idle:  o_ready = 1'b1;
         c_run:   o_busy  = 1'b1;
         c_done:  begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
         end
         default: o_ready = 1'b0;
      endcase
   end

   // Operand capture; only meaningful after an accept, so no reset needed
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_a <= i_a;
         r_b <= i_b;
      end
   end

   // Chunk counter, inter-chunk carry and result registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_carry <= i_carry_in;
      end else if (r_state == c_run) begin
         r_s[r_cnt] <= w_sum;
         r_carry    <= w_cout;
         r_cnt      <= r_cnt + 1'b1;
         if (r_cnt == c_last) begin
            r_cout <= w_cout;
         end
      end
   end

   assign o_s         = r_s;
   assign o_carry_out = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_chunked_adder_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_chunked_adder_seq
// Description : Self-checking bench for chunked_adder_seq (K=4 and K=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_chunked_adder_seq;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [63:0] s;
      logic        cout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   // 64-bit, 4-chunk instance
   logic        in_valid, out_ready, out_valid, in_rdy, out_cout, out_busy, in_cin;
   logic [63:0] in_a, in_b, out_s;
   // 16-bit, single-chunk instance
   logic        v16, r16, ov16, ir16, co16, busy16, cin16;
   logic [15:0] a16, b16, s16;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   chunked_adder_seq #(.N(64), .W(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .o_ready(out_ready),
      .i_a(in_a), .i_b(in_b), .i_carry_in(in_cin), .o_valid(out_valid),
      .i_ready(in_rdy), .o_s(out_s), .o_carry_out(out_cout), .o_busy(out_busy)
   );

   chunked_adder_seq #(.N(16), .W(16)) dut16 (
      .i_clk(clk), .i_reset(rst), .i_valid(v16), .o_ready(r16),
      .i_a(a16), .i_b(b16), .i_carry_in(cin16), .o_valid(ov16),
      .i_ready(ir16), .o_s(s16), .o_carry_out(co16), .o_busy(busy16)
   );

   function automatic void check(string nm, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   // Issue one request on the 64-bit instance; returns result and the number
   // of rising edges between the accept edge and o_valid being seen
   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        output logic [63:0] s, output logic c, output int lat);
      @(negedge clk);
      check("accept_ready", out_ready, 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      s = out_s; c = out_cout;
   endtask

   task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic c, output int lat);
      @(negedge clk);
      check("k1_accept_ready", r16, 1);
      v16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
      @(posedge clk);
      @(negedge clk);
      v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      lat = 0;
      while (!ov16 && lat < 50) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      s = s16; c = co16;
   endtask

   // Let the handshake edge pass and confirm return to IDLE
   task automatic finish_op(string nm);
      @(posedge clk);
      @(negedge clk);
      check({nm, "_ready_after"}, {out_ready, out_valid, out_busy}, 3'b100);
   endtask

   initial begin
      vec_t        vecs[7];
      logic [63:0] s;
      logic        c;
      logic [15:0] s_16;
      logic        c_16;
      int          lat;
      logic [64:0] model;
      logic        seen;

      vecs[0] = '{64'd1, 64'd0, 1'b0, 64'd1, 1'b0};
      vecs[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
      vecs[3] = '{64'd5, 64'd7, 1'b0, 64'd12, 1'b0};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
      vecs[5] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h0001_0000_0000_0001, 1'b0};
      vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_rdy = 1'b1; in_a = '0; in_b = '0; in_cin = 1'b0;
      v16 = 1'b0; ir16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_s", out_s, 0);
      check("reset_cout", out_cout, 0);
      check("reset_flags", {out_ready, out_valid, out_busy}, 3'b100);
      check("k1_reset", {r16, ov16, busy16, co16, s16}, {3'b100, 1'b0, 16'd0});

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_sum", i), {c, s}, {vecs[i].cout, vecs[i].s});
         finish_op($sformatf("vec%0d", i));
      end

      // Max wrap under backpressure
      in_rdy = 1'b0;
      do_op('1, '1, 1'b1, s, c, lat);
      check("bp_latency", lat, 4);
      check("bp_sum", {c, s}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      seen = 1'b1;
      repeat (10) begin
         @(posedge clk); @(negedge clk);
         if (!(out_valid && out_s == 64'hFFFF_FFFF_FFFF_FFFF && out_cout && !out_ready))
            seen = 1'b0;
      end
      check("bp_stable", seen, 1);
      in_rdy = 1'b1;
      finish_op("bp");

      // Busy rejection and operand isolation
      @(negedge clk);
      in_valid = 1'b1; in_a = 64'd5; in_b = 64'd7; in_cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_a = 64'd100; in_b = 64'd100;
      check("busy_not_ready", {out_ready, out_busy}, 2'b01);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      check("busy_latency", lat, 4);
      check("busy_sum", {out_cout, out_s}, 65'd12);
      finish_op("busy");

      // Reset during RUN discards the operation
      @(negedge clk);
      in_valid = 1'b1; in_a = '1; in_b = '1; in_cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_flags", {out_ready, out_valid, out_busy}, 3'b100);
      check("midrst_s", {out_cout, out_s}, 65'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_valid", seen, 0);
      do_op(64'd3, 64'd4, 1'b0, s, c, lat);
      check("post_rst_latency", lat, 4);
      check("post_rst_sum", {c, s}, 65'd7);
      finish_op("post_rst");

      // Single-chunk instance
      do_op16(16'd1, 16'd0, 1'b0, s_16, c_16, lat);
      check("k1_latency", lat, 1);
      check("k1_sum", {c_16, s_16}, 17'd1);
      @(posedge clk); @(negedge clk);
      check("k1_idle_after", {r16, ov16, busy16}, 3'b100);
      do_op16(16'hFFFF, 16'hFFFF, 1'b1, s_16, c_16, lat);
      check("k1_wrap", {c_16, s_16}, {1'b1, 16'hFFFF});
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         logic [15:0] ra, rb;
         logic        rc;
         logic [16:0] m16;
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         m16 = ra + rb + rc;
         do_op16(ra, rb, rc, s_16, c_16, lat);
         check($sformatf("k1_rand%0d", i), {lat[7:0], c_16, s_16}, {8'd1, m16});
         @(posedge clk);
      end

      // Randomized traffic against arithmetic model, with random consumer stalls
      for (int i = 0; i < 40; i++) begin
         logic [63:0] ra, rb;
         logic        rc;
         int          stall;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 5 == 0) ra = '1;
         if (i % 7 == 0) rb = ~ra;
         rc = 1'($urandom);
         model = 65'(ra) + 65'(rb) + 65'(rc);
         stall = $urandom_range(0, 3);
         in_rdy = (stall == 0);
         do_op(ra, rb, rc, s, c, lat);
         check($sformatf("rand%0d", i), {lat[7:0], c, s}, {8'd4, model});
         if (stall != 0) begin
            repeat (stall) @(posedge clk);
            @(negedge clk);
            check($sformatf("rand%0d_hold", i), {out_valid, out_cout, out_s}, {1'b1, model});
            in_rdy = 1'b1;
         end
         finish_op($sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
- Multi-cycle sequencer that adds two N-bit operands by time-multiplexing one W-bit instance of the team's `adder` module (parameter N set to W), one W-bit chunk per cycle, LSB chunk first.
- Owns the operand and result registers, the carry register between chunks, the chunk counter, and the valid/ready handshakes on both sides.
- Trades latency for area wherever wide additions (e.g. 64/128-bit) are needed.

Parameters:
- N, 64, operand/result width; N % W == 0 and N >= W are required (elaboration error otherwise).
- W, 16, width of the shared adder instance (chunk width).
- Derived: K = N/W chunks; counter width = max(1, $clog2(K)).

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_valid  in  1  request valid
- o_ready  out  1  sequencer can accept a request (IDLE only)
- i_a  in  N  operand A, sampled on accept edge only
- i_b  in  N  operand B, sampled on accept edge only
- i_carry_in  in  1  carry into chunk 0, sampled on accept edge only
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_s  out  N  sum, registered
- o_carry_out  out  1  carry out of chunk K-1, registered
- o_busy  out  1  high in RUN or DONE

Behaviour:
- Reset (i_reset=1 at an edge, any state, including mid-RUN): state=IDLE, o_s=0, o_carry_out=0, o_valid=0, o_busy=0, counter=0, carry reg=0. The in-flight operation is discarded and no o_valid is produced for it.
- States: IDLE, RUN, DONE. o_ready = (state==IDLE); o_valid = (state==DONE); o_busy = (state!=IDLE).
- IDLE: on edge with i_valid & o_ready, latch i_a, i_b, and carry reg <= i_carry_in; counter <= 0; go to RUN. o_s and o_carry_out keep the previous result; they are not cleared.
- RUN: adder inputs are A[cnt*W +: W], B[cnt*W +: W], and carry reg.
  - Each edge: o_s[cnt*W +: W] <= adder sum; carry reg <= adder carry; cnt <= cnt+1.
  - At the edge processing cnt==K-1: o_carry_out <= adder carry; go to DONE.
- Latency: o_valid rises exactly K edges after the accept edge (4 for defaults). No combinational path from i_a/i_b to o_s.
- DONE: o_s and o_carry_out stable while o_valid=1 and i_ready=0 (backpressure, unbounded). On edge with o_valid & i_ready, go to IDLE.
- No new request is accepted in the same cycle as the result handshake. Minimum initiation interval is K+2 cycles.
- i_valid while not in IDLE is ignored and not queued. The requester must hold i_valid until it sees o_ready.
- Arithmetic: {o_carry_out, o_s} == i_a + i_b + i_carry_in modulo 2^(N+1); wrap-around is exact (all-ones + all-ones + 1 -> o_s all-ones, carry 1).
- K==1 (N==W): RUN lasts one cycle; counter logic must still elaborate.
- Changes on i_a/i_b/i_carry_in after the accept edge have no effect on the result.

Test Plan (N=64, W=16 unless noted):
- Reset then idle: after i_reset held 2 cycles -> o_s=0, o_carry_out=0, o_valid=0, o_ready=1, o_busy=0.
- a=1, b=0, cin=0, i_ready=1 -> o_valid exactly 4 cycles after accept, o_s=1, cout=0; back in IDLE next cycle.
- Carry ripple across chunks: a=64'h0000_0000_0000_FFFF, b=1, cin=0 -> o_s=64'h0000_0000_0001_0000, cout=0. Also a=2^64-1, b=0, cin=1 -> o_s=0, cout=1.
- Max wrap and backpressure: a=b=2^64-1, cin=1, i_ready=0 for 10 cycles -> o_s=2^64-1, cout=1, stable with o_valid=1 the whole time. Raising i_ready returns to IDLE after one edge.
- Busy rejection and operand isolation: accept a=5, b=7; on the next cycle drive i_valid=1, a=100, b=100 -> o_ready=0 and the request is ignored; result o_s=12.
- Reset mid-RUN: accept a=b=2^64-1, assert i_reset after 2 RUN cycles -> next cycle IDLE, o_s=0, o_valid never rises. A following request a=3, b=4 yields o_s=7. Repeat the basic case with N=W=16 (K=1): o_valid 1 cycle after accept.
